// File: rtl/n64_cart_bus_bridge.sv
// n64_cart_bus_bridge
//   Bridges the N64 cartridge AD bus to two simple request/acknowledge ports.
//   An address is assembled from two ALE strobes. When it falls inside the cart
//   window, the word at that offset is prefetched over the read port. Cart read
//   pulses return the prefetched word and then fetch the next one. Cart write
//   pulses are forwarded over the write port.
//
// Ports
//   clk, rst                        system clock, synchronous active-high reset
//   n64_ad_in / n64_ad_out / n64_ad_oe   cart AD bus sample, drive value, drive enable
//   n64_ale_h, n64_ale_l            address latch strobes (high / low half)
//   n64_read_n, n64_write_n         active-low cart read / write strobes
//   writeport_wr/addr/data/ack      write request port (four-phase handshake)
//   readport_rd/addr/data/ack       read request port (four-phase handshake)
//   read_underrun                   sticky: a read strobe arrived before its word was fetched
module n64_cart_bus_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          ADDR_BITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] n64_ad_in,
  output logic [15:0] n64_ad_out,
  output logic        n64_ad_oe,
  input  logic        n64_ale_h,
  input  logic        n64_ale_l,
  input  logic        n64_read_n,
  input  logic        n64_write_n,
  output logic        writeport_wr,
  output logic [31:0] writeport_addr,
  output logic [15:0] writeport_data,
  input  logic        writeport_ack,
  output logic        readport_rd,
  output logic [31:0] readport_addr,
  input  logic [15:0] readport_data,
  input  logic        readport_ack,
  output logic        read_underrun
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_REL, READY, WR_REQ, WR_REL} state_t;

  localparam logic [ADDR_BITS-1:0] STEP2 = ADDR_BITS'(2);
  localparam logic [ADDR_BITS-1:0] STEP4 = ADDR_BITS'(4);

  // Stage p0/p1: two-flop synchronizers. Stage p2: previous value for edge detect.
  // Strobe bits are {write_n, read_n, ale_l, ale_h}; they reset to their idle levels.
  logic [15:0] ad_p0, ad_p1;
  logic [3:0]  strb_p0, strb_p1, strb_p2;

  always_ff @(posedge clk) begin
    ad_p0 <= n64_ad_in;
    ad_p1 <= ad_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strb_p0 <= 4'b1100;
      strb_p1 <= 4'b1100;
      strb_p2 <= 4'b1100;
    end else begin
      strb_p0 <= {n64_write_n, n64_read_n, n64_ale_l, n64_ale_h};
      strb_p1 <= strb_p0;
      strb_p2 <= strb_p1;
    end
  end

  logic ale_h_fall, ale_l_fall, rd_fall, rd_rise, wr_rise;
  assign ale_h_fall = strb_p2[0] & ~strb_p1[0];
  assign ale_l_fall = strb_p2[1] & ~strb_p1[1];
  assign rd_fall    = strb_p2[2] & ~strb_p1[2];
  assign rd_rise    = ~strb_p2[2] & strb_p1[2];
  assign wr_rise    = ~strb_p2[3] & strb_p1[3];

  state_t               state;
  logic [15:0]          addr_hi, word_buf, wr_buf;
  logic [ADDR_BITS-1:0] offset, na_off;
  logic                 in_win, na_win, buf_valid;
  logic                 pend_new, pend_adv, pend_wr;

  logic [31:0]          new_addr, new_diff, off_ext;
  logic                 new_in, tgt_win, want_new, want_adv, want_wr, free, adv_first;
  logic [ADDR_BITS-1:0] new_off, tgt_off;
  logic [15:0]          wr_src;

  // Window decode and the merged view of fresh events plus recorded pending ones.
  always_comb begin
    new_addr  = {addr_hi, ad_p1};
    new_diff  = new_addr - BASE_ADDR;
    new_in    = (new_addr >= BASE_ADDR) && ((new_diff >> ADDR_BITS) == 32'd0);
    new_off   = new_diff[ADDR_BITS-1:0];
    tgt_off   = ale_l_fall ? new_off : na_off;
    tgt_win   = ale_l_fall ? new_in : na_win;
    wr_src    = wr_rise ? ad_p1 : wr_buf;
    want_new  = pend_new | ale_l_fall;
    want_adv  = pend_adv | (rd_rise & in_win);
    want_wr   = pend_wr | (wr_rise & in_win);
    // A handshake is only finished once the responder has dropped its ack.
    free      = (state == IDLE) || (state == READY) ||
                ((state == RD_REL) && !readport_ack) ||
                ((state == WR_REL) && !writeport_ack);
    // Recorded events replay as new_addr, advance, write; fresh simultaneous
    // cart strobes are serviced write first.
    adv_first = (state == RD_REL);
    off_ext   = 32'(offset);
  end

  assign readport_addr  = off_ext & ~32'd1;
  assign writeport_addr = off_ext & ~32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      n64_ad_oe      <= 1'b0;
      n64_ad_out     <= 16'h0000;
      readport_rd    <= 1'b0;
      writeport_wr   <= 1'b0;
      writeport_data <= 16'h0000;
      read_underrun  <= 1'b0;
      offset         <= '0;
      in_win         <= 1'b0;
      na_win         <= 1'b0;
      buf_valid      <= 1'b0;
      pend_new       <= 1'b0;
      pend_adv       <= 1'b0;
      pend_wr        <= 1'b0;
    end else begin
      if (ale_h_fall) addr_hi <= ad_p1;
      if (ale_l_fall) begin
        na_off <= new_off;
        na_win <= new_in;
      end
      if (wr_rise && in_win) wr_buf <= ad_p1;
      if (rd_fall && in_win) begin
        n64_ad_oe  <= 1'b1;
        n64_ad_out <= word_buf;
        if (!buf_valid) read_underrun <= 1'b1;
      end
      if (rd_rise && in_win) n64_ad_oe <= 1'b0;

      case (state)
        RD_REQ: if (readport_ack) begin
          word_buf    <= readport_data;
          buf_valid   <= ~want_new;
          readport_rd <= 1'b0;
          state       <= RD_REL;
        end
        WR_REQ: if (writeport_ack) begin
          writeport_wr <= 1'b0;
          state        <= WR_REL;
        end
        default: ;
      endcase

      if (!free) begin
        pend_new <= want_new;
        pend_adv <= want_adv;
        pend_wr  <= want_wr;
      end else begin
        pend_new <= 1'b0;
        if (want_new) begin
          buf_valid <= 1'b0;
          if (tgt_win) begin
            offset      <= tgt_off;
            in_win      <= 1'b1;
            readport_rd <= 1'b1;
            state       <= RD_REQ;
            pend_adv    <= want_adv;
            pend_wr     <= want_wr;
          end else begin
            // Out of window: keep the old offset, drop the bus, ignore strobes.
            in_win    <= 1'b0;
            n64_ad_oe <= 1'b0;
            state     <= IDLE;
            pend_adv  <= 1'b0;
            pend_wr   <= 1'b0;
          end
        end else if (state == WR_REL) begin
          // The completed write consumes its word; a pending advance skips one more.
          buf_valid <= 1'b0;
          if (want_adv) begin
            offset      <= offset + STEP4;
            readport_rd <= 1'b1;
            state       <= RD_REQ;
            pend_adv    <= 1'b0;
            pend_wr     <= want_wr;
          end else if (want_wr) begin
            offset         <= offset + STEP2;
            writeport_wr   <= 1'b1;
            writeport_data <= wr_src;
            state          <= WR_REQ;
            pend_wr        <= 1'b0;
          end else begin
            offset      <= offset + STEP2;
            readport_rd <= 1'b1;
            state       <= RD_REQ;
          end
        end else if (want_adv && (adv_first || !want_wr)) begin
          offset      <= offset + STEP2;
          buf_valid   <= 1'b0;
          readport_rd <= 1'b1;
          state       <= RD_REQ;
          pend_adv    <= 1'b0;
          pend_wr     <= want_wr;
        end else if (want_wr) begin
          writeport_wr   <= 1'b1;
          writeport_data <= wr_src;
          state          <= WR_REQ;
          pend_wr        <= 1'b0;
          pend_adv       <= want_adv;
        end else begin
          state    <= in_win ? READY : IDLE;
          pend_adv <= 1'b0;
          pend_wr  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_n64_cart_bus_bridge.sv
// Directed bench for n64_cart_bus_bridge: a table of cart-side operations with
// the expected port state after each, followed by a few hand-written sequences
// (mid-run reset, behaviour after reset, address change during a handshake).
module tb_n64_cart_bus_bridge;
  localparam int OP_NOP = 0;
  localparam int OP_ALE = 1;
  localparam int OP_RDL = 2;
  localparam int OP_RDH = 3;
  localparam int OP_WR  = 4;

  typedef struct {
    int          op;
    logic [31:0] arg;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] resp;
    logic        oe;
    logic [15:0] ad_out;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic        und;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] n64_ad_in;
  logic [15:0] n64_ad_out;
  logic        n64_ad_oe;
  logic        n64_ale_h, n64_ale_l, n64_read_n, n64_write_n;
  logic        writeport_wr;
  logic [31:0] writeport_addr;
  logic [15:0] writeport_data;
  logic        writeport_ack = 1'b0;
  logic        readport_rd;
  logic [31:0] readport_addr;
  logic [15:0] readport_data = 16'h0000;
  logic        readport_ack = 1'b0;
  logic        read_underrun;

  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] resp  = 16'h0000;
  logic        both_seen = 1'b0;
  int          total  = 0;
  int          passed = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  n64_cart_bus_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .n64_ad_in     (n64_ad_in),
    .n64_ad_out    (n64_ad_out),
    .n64_ad_oe     (n64_ad_oe),
    .n64_ale_h     (n64_ale_h),
    .n64_ale_l     (n64_ale_l),
    .n64_read_n    (n64_read_n),
    .n64_write_n   (n64_write_n),
    .writeport_wr  (writeport_wr),
    .writeport_addr(writeport_addr),
    .writeport_data(writeport_data),
    .writeport_ack (writeport_ack),
    .readport_rd   (readport_rd),
    .readport_addr (readport_addr),
    .readport_data (readport_data),
    .readport_ack  (readport_ack),
    .read_underrun (read_underrun)
  );

  // Responder: acks follow the requests half a cycle later while enabled.
  always @(negedge clk) begin
    readport_ack  = rd_en && readport_rd;
    writeport_ack = wr_en && writeport_wr;
    readport_data = resp;
    if (readport_rd && writeport_wr) both_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_op(input int op, input logic [31:0] arg);
    case (op)
      OP_ALE: begin
        n64_ale_h = 1'b1; n64_ale_l = 1'b1; n64_ad_in = arg[31:16]; step(4);
        n64_ale_h = 1'b0; step(4);
        n64_ad_in = arg[15:0]; step(4);
        n64_ale_l = 1'b0; step(4);
      end
      OP_RDL: n64_read_n = 1'b0;
      OP_RDH: n64_read_n = 1'b1;
      OP_WR: begin
        n64_ad_in = arg[15:0]; step(4);
        n64_write_n = 1'b0; step(4);
        n64_write_n = 1'b1; step(4);
      end
      default: ;
    endcase
  endtask

  function automatic vec_t mk(int op, logic [31:0] arg, logic re, logic we, logic [15:0] rs,
                              logic oe, logic [15:0] ado, logic rd, logic wr,
                              logic [31:0] addr, logic [15:0] wd, logic und);
    vec_t v;
    v.op = op; v.arg = arg; v.rd_en = re; v.wr_en = we; v.resp = rs;
    v.oe = oe; v.ad_out = ado; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd; v.und = und;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_oe"},    32'(n64_ad_oe), 32'd0);
    chk({tag, "_adout"}, 32'(n64_ad_out), 32'd0);
    chk({tag, "_rd"},    32'(readport_rd), 32'd0);
    chk({tag, "_wr"},    32'(writeport_wr), 32'd0);
    chk({tag, "_raddr"}, readport_addr, 32'd0);
    chk({tag, "_waddr"}, writeport_addr, 32'd0);
    chk({tag, "_wdata"}, 32'(writeport_data), 32'd0);
    chk({tag, "_und"},   32'(read_underrun), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    n64_ad_in = 16'h0000; n64_ale_h = 1'b0; n64_ale_l = 1'b0;
    n64_read_n = 1'b1; n64_write_n = 1'b1;

    //        op      arg           re  we  resp      oe  ad_out    rd  wr  addr           wdata     und
    vecs.push_back(mk(OP_ALE, 32'h1000_0100, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 32'h0000_0100, 16'h0000, 0));
    vecs.push_back(mk(OP_NOP, 32'h0,         1, 0, 16'hBEEF, 0, 16'h0000, 0, 0, 32'h0000_0100, 16'h0000, 0));
    vecs.push_back(mk(OP_RDL, 32'h0,         1, 0, 16'hBEEF, 1, 16'hBEEF, 0, 0, 32'h0000_0100, 16'h0000, 0));
    vecs.push_back(mk(OP_RDH, 32'h0,         0, 0, 16'hBEEF, 0, 16'h0000, 1, 0, 32'h0000_0102, 16'h0000, 0));
    vecs.push_back(mk(OP_NOP, 32'h0,         1, 0, 16'h1111, 0, 16'h0000, 0, 0, 32'h0000_0102, 16'h0000, 0));
    vecs.push_back(mk(OP_RDL, 32'h0,         1, 0, 16'h1111, 1, 16'h1111, 0, 0, 32'h0000_0102, 16'h0000, 0));
    vecs.push_back(mk(OP_RDH, 32'h0,         1, 0, 16'h1111, 0, 16'h0000, 0, 0, 32'h0000_0104, 16'h0000, 0));
    vecs.push_back(mk(OP_ALE, 32'h1000_0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 32'h0000_0000, 16'h0000, 0));
    vecs.push_back(mk(OP_WR,  32'h1234,      0, 0, 16'h0000, 0, 16'h0000, 0, 1, 32'h0000_0000, 16'h1234, 0));
    vecs.push_back(mk(OP_NOP, 32'h0,         0, 1, 16'h0000, 0, 16'h0000, 1, 0, 32'h0000_0002, 16'h1234, 0));
    vecs.push_back(mk(OP_NOP, 32'h0,         1, 1, 16'h2222, 0, 16'h0000, 0, 0, 32'h0000_0002, 16'h1234, 0));
    vecs.push_back(mk(OP_RDL, 32'h0,         1, 1, 16'h2222, 1, 16'h2222, 0, 0, 32'h0000_0002, 16'h1234, 0));
    vecs.push_back(mk(OP_RDH, 32'h0,         0, 1, 16'h2222, 0, 16'h0000, 1, 0, 32'h0000_0004, 16'h1234, 0));
    vecs.push_back(mk(OP_RDL, 32'h0,         0, 1, 16'h2222, 1, 16'h2222, 1, 0, 32'h0000_0004, 16'h1234, 1));
    vecs.push_back(mk(OP_RDH, 32'h0,         0, 1, 16'h2222, 0, 16'h0000, 1, 0, 32'h0000_0004, 16'h1234, 1));
    vecs.push_back(mk(OP_NOP, 32'h0,         1, 1, 16'h3333, 0, 16'h0000, 0, 0, 32'h0000_0006, 16'h1234, 1));
    vecs.push_back(mk(OP_ALE, 32'h0500_0000, 1, 1, 16'h3333, 0, 16'h0000, 0, 0, 32'h0000_0006, 16'h1234, 1));
    vecs.push_back(mk(OP_RDL, 32'h0,         1, 1, 16'h3333, 0, 16'h0000, 0, 0, 32'h0000_0006, 16'h1234, 1));
    vecs.push_back(mk(OP_RDH, 32'h0,         1, 1, 16'h3333, 0, 16'h0000, 0, 0, 32'h0000_0006, 16'h1234, 1));
    vecs.push_back(mk(OP_WR,  32'h5555,      1, 0, 16'h3333, 0, 16'h0000, 0, 0, 32'h0000_0006, 16'h1234, 1));
    vecs.push_back(mk(OP_ALE, 32'h1200_0000, 1, 1, 16'h3333, 0, 16'h0000, 0, 0, 32'h0000_0006, 16'h1234, 1));
    vecs.push_back(mk(OP_ALE, 32'h0FFF_FFFE, 1, 1, 16'h3333, 0, 16'h0000, 0, 0, 32'h0000_0006, 16'h1234, 1));
    vecs.push_back(mk(OP_ALE, 32'h11FF_FFFE, 0, 1, 16'h3333, 0, 16'h0000, 1, 0, 32'h01FF_FFFE, 16'h1234, 1));
    vecs.push_back(mk(OP_NOP, 32'h0,         1, 1, 16'h4444, 0, 16'h0000, 0, 0, 32'h01FF_FFFE, 16'h1234, 1));
    vecs.push_back(mk(OP_RDL, 32'h0,         1, 1, 16'h4444, 1, 16'h4444, 0, 0, 32'h01FF_FFFE, 16'h1234, 1));
    vecs.push_back(mk(OP_RDH, 32'h0,         0, 1, 16'h4444, 0, 16'h0000, 1, 0, 32'h0000_0000, 16'h1234, 1));

    step(3);
    chk_all_zero("reset");
    rst = 1'b0;
    step(2);

    for (int i = 0; i < vecs.size(); i++) begin
      rd_en = vecs[i].rd_en;
      wr_en = vecs[i].wr_en;
      resp  = vecs[i].resp;
      do_op(vecs[i].op, vecs[i].arg);
      step(12);
      chk($sformatf("v%0d_oe", i),    32'(n64_ad_oe), 32'(vecs[i].oe));
      if (vecs[i].oe) chk($sformatf("v%0d_adout", i), 32'(n64_ad_out), 32'(vecs[i].ad_out));
      chk($sformatf("v%0d_rd", i),    32'(readport_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_wr", i),    32'(writeport_wr), 32'(vecs[i].wr));
      chk($sformatf("v%0d_raddr", i), readport_addr, vecs[i].addr);
      chk($sformatf("v%0d_waddr", i), writeport_addr, vecs[i].addr);
      chk($sformatf("v%0d_wdata", i), 32'(writeport_data), 32'(vecs[i].wdata));
      chk($sformatf("v%0d_und", i),   32'(read_underrun), 32'(vecs[i].und));
    end

    // Reset mid-handshake: every output low one edge later.
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("midrst");
    step(1);
    rst = 1'b0;
    step(2);

    // After reset the bridge has no window, so cart reads are ignored.
    rd_en = 1'b1;
    do_op(OP_RDL, 32'h0); step(12);
    chk("postrst_oe", 32'(n64_ad_oe), 32'd0);
    chk("postrst_rd", 32'(readport_rd), 32'd0);
    do_op(OP_RDH, 32'h0); step(12);
    chk("postrst_rd2", 32'(readport_rd), 32'd0);

    // New address while a fetch is stalled: the fetch completes untouched,
    // its data is dropped, and the new address is fetched afterwards.
    rd_en = 1'b0;
    do_op(OP_ALE, 32'h1000_0010); step(12);
    chk("pend_rd1",   32'(readport_rd), 32'd1);
    chk("pend_addr1", readport_addr, 32'h10);
    do_op(OP_ALE, 32'h1000_0020); step(12);
    chk("pend_rd2",   32'(readport_rd), 32'd1);
    chk("pend_addr2", readport_addr, 32'h10);
    resp = 16'h5A5A;
    rd_en = 1'b1;
    step(12);
    chk("pend_rd3",   32'(readport_rd), 32'd0);
    chk("pend_addr3", readport_addr, 32'h20);
    do_op(OP_RDL, 32'h0); step(12);
    chk("pend_oe",    32'(n64_ad_oe), 32'd1);
    chk("pend_adout", 32'(n64_ad_out), 32'h5A5A);
    chk("pend_und",   32'(read_underrun), 32'd0);
    do_op(OP_RDH, 32'h0); step(12);
    chk("pend_addr4", readport_addr, 32'h22);

    chk("rd_wr_exclusive", 32'(both_seen), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/n64_cart_bus_bridge.md
N64_CART_BUS_BRIDGE -- requirements
Module: n64_cart_bus_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000: start of the cart window the bridge decodes.
REQ-002 SHALL have parameter ADDR_BITS, default 25: window size of 2^ADDR_BITS bytes (32 MB).
REQ-003 SHALL have one clock and a synchronous, active-high reset; no other clock or reset port.
REQ-004 clk  in  1  system clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 n64_ad_in  in  16  cart AD bus input.
REQ-007 n64_ad_out  out  16  cart AD bus drive value.
REQ-008 n64_ad_oe  out  1  cart AD bus output enable.
REQ-009 n64_ale_h / n64_ale_l  in  1 each  address latch strobes, high half / low half.
REQ-010 n64_read_n / n64_write_n  in  1 each  active-low read / write strobes.
REQ-011 writeport_wr  out  1; writeport_addr  out  32; writeport_data  out  16; writeport_ack  in  1: write request port.
REQ-012 readport_rd  out  1; readport_addr  out  32; readport_data  in  16; readport_ack  in  1: read request port.
REQ-013 read_underrun  out  1  sticky flag: a read strobe arrived before its word was fetched.

Function
REQ-014 Cart inputs SHALL pass through 2-flop synchronizers; edges SHALL be detected on synchronized signals only.
REQ-015 Falling edge of ale_h SHALL latch n64_ad_in into addr[31:16]; falling edge of ale_l SHALL latch it into addr[15:0] and start a new transaction.
REQ-016 In-window test SHALL be BASE_ADDR <= addr < BASE_ADDR + 2^ADDR_BITS; offset = addr - BASE_ADDR, width ADDR_BITS, zero-extended to 32 bits.
REQ-017 Both writeport_addr and readport_addr SHALL carry the current offset with bit 0 forced to 0, whichever port is active.
REQ-018 Out-of-window transactions SHALL enter IDLE: no requests, n64_ad_oe held 0, and write strobes ignored.
REQ-019 The FSM SHALL have the states IDLE, RD_REQ, RD_REL, READY, WR_REQ and WR_REL.
REQ-020 RD_REQ: readport_rd=1. On the first cycle readport_ack=1 is sampled, capture readport_data into word_buf, set buf_valid, drive readport_rd=0 the next cycle, and go to RD_REL.
REQ-021 RD_REL: wait for readport_ack=0, then go to READY (or apply pending actions, REQ-026).
REQ-022 WR_REQ: writeport_wr=1 with writeport_data=wr_buf. Ack high -> writeport_wr=0 next cycle and go to WR_REL.
REQ-023 WR_REL: wait for readport-independent writeport_ack=0, then offset += 2, buf_valid=0, go to RD_REQ.
REQ-024 A valid in-window ale_l fall SHALL set buf_valid=0 and go to RD_REQ (prefetch).
REQ-025 read_n fall SHALL set n64_ad_oe=1 and n64_ad_out=word_buf. If buf_valid=0 at that moment, it SHALL also set read_underrun=1.
REQ-026 read_n rise SHALL set n64_ad_oe=0, offset += 2, buf_valid=0, then go to RD_REQ.
REQ-027 write_n rise SHALL latch n64_ad_in into wr_buf and go to WR_REQ.
REQ-028 Offset increments SHALL wrap modulo 2^ADDR_BITS.
REQ-029 A handshake in flight SHALL never be aborted. Events arriving during RD_REQ/RD_REL/WR_REQ/WR_REL SHALL be recorded in pending flags (new_addr, advance, write) and applied in that order once the handshake returns to idle-ack.
REQ-030 Data fetched under a pending new_addr SHALL be discarded (buf_valid stays 0).
REQ-031 If read_n and write_n edges occur in the same cycle, the write SHALL be processed first.
REQ-032 readport_rd and writeport_wr SHALL never both be 1.

Reset
REQ-033 On rst=1, all outputs SHALL be 0 on the next edge: n64_ad_oe, n64_ad_out, writeport_wr, readport_rd, both addr outputs, writeport_data and read_underrun.
REQ-034 On rst=1, the FSM SHALL enter IDLE and buf_valid and all pending flags SHALL clear, including mid-handshake.
REQ-035 read_underrun SHALL clear only on reset.

Verification
REQ-036 rst pulse mid-run -> all outputs 0 the next cycle, FSM in IDLE.
REQ-037 ALE sequence 0x1000/0x0100, responder acks with 0xBEEF -> readport_rd=1 with readport_addr=0x100. Then read_n low -> oe=1, ad_out=0xBEEF. Then read_n high -> oe=0 and a new readport_rd with addr=0x102.
REQ-038 ALE to 0x1000_0000, write_n pulse with AD=0x1234 -> writeport_wr=1, writeport_addr=0, writeport_data=0x1234. After ack low -> readport_rd with addr=0x2.
REQ-039 Responder withholds readport_ack and read_n falls -> read_underrun=1, held through later transactions until rst.
REQ-040 ALE to 0x0500_0000 followed by read and write pulses -> no requests issued, oe stays 0.
REQ-041 ALE to 0x11FF_FFFE, two read pulses -> prefetch addresses 0x1FF_FFFE and then 0x000_0000 (wrap).
